cdb_arbiter: RTL

//   Grants the common data bus (CDB) to exactly one functional-unit output buffer per cycle.

---
 rtl/out_of_order_pkg.sv | 9 +
 rtl/rr_priority_select.sv | 44 ++++
 rtl/cdb_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/out_of_order_pkg.sv
// Shared out-of-order core definitions: system functional-unit count and the
// CDB grant index type used by the ROB, FU instantiation and the CDB arbiter.
package out_of_order_pkg;

    localparam int CDB_N_REQ = 4;

    typedef logic [$clog2(CDB_N_REQ)-1:0] cdb_idx_t;

endpackage : out_of_order_pkg

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: rotate requests so ptr is at slot 0,
// take the first set slot, and map it back to the original index.
module rr_priority_select #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    logic [IDX_W-1:0] pos [N];
    logic [N-1:0]     rot;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W:0] sum;
            // Compare-and-subtract wrap keeps non-power-of-2 N correct.
            assign sum     = {1'b0, ptr} + (IDX_W+1)'(gi);
            assign pos[gi] = (sum >= (IDX_W+1)'(N)) ? IDX_W'(sum - (IDX_W+1)'(N))
                                                    : IDX_W'(sum);
            assign rot[gi] = req[pos[gi]];
        end
    endgenerate

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                idx   = pos[k];
            end
        end
        if (valid) begin
            grant[idx] = 1'b1;
        end
    end

endmodule : rr_priority_select

// File: rtl/cdb_arbiter.sv
// Round-robin common data bus arbiter with flush/reset gating and a sticky
// starvation checker built from per-requester wait counters.
module cdb_arbiter
    import out_of_order_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int IDX_W  = $clog2(N_REQ),
    parameter int WAIT_W = $clog2(N_REQ) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] request,
    input  logic             flush,
    output logic [N_REQ-1:0] cdb_permit,
    output logic             cdb_active,
    output logic [IDX_W-1:0] grant_idx,
    output logic             starvation_error
);

    logic [IDX_W-1:0]  prio_ptr_q, prio_ptr_d;
    logic [WAIT_W-1:0] wait_cnt_q [N_REQ];
    logic [WAIT_W-1:0] wait_cnt_d [N_REQ];
    logic              starvation_error_q, starvation_error_d;

    logic [N_REQ-1:0]  sel_grant;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_valid;
    logic              grant_en;

    rr_priority_select #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_select (
        .req   (request),
        .ptr   (prio_ptr_q),
        .grant (sel_grant),
        .idx   (sel_idx),
        .valid (sel_valid)
    );

    // A grant in the reset cycle would pop a buffer entry the pipeline never sees.
    assign grant_en         = reset & ~flush & sel_valid;
    assign cdb_permit       = grant_en ? sel_grant : '0;
    assign cdb_active       = grant_en;
    assign grant_idx        = grant_en ? sel_idx : '0;
    assign starvation_error = starvation_error_q;

    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (grant_en) begin
            prio_ptr_d = (sel_idx == IDX_W'(N_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (!request[i] || cdb_permit[i]) begin
                wait_cnt_d[i] = '0;
            end else if (!flush && (wait_cnt_q[i] != '1)) begin
                wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        starvation_error_d = starvation_error_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (wait_cnt_q[i] > WAIT_W'(N_REQ - 1)) begin
                starvation_error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_ptr_q         <= '0;
            starvation_error_q <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            prio_ptr_q         <= prio_ptr_d;
            starvation_error_q <= starvation_error_d;
            for (int i = 0; i < N_REQ; i++) begin
                wait_cnt_q[i] <= wait_cnt_d[i];
            end
        end
    end

endmodule : cdb_arbiter
